data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 108 ++++++++++
 tb/tb_data_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: serves one byte-wide load or store per request after a fixed
// wait, stalling the pipeline meanwhile, and flags malformed or out-of-range requests.
module data_mem_ctrl #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       MemRead,
    input  logic       MemWrite,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       stall,
    output logic       done,
    output logic       err,
    output logic [1:0] fsmState
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } stateT;

    stateT state, nextState;

    logic [7:0]            mem [DEPTH];
    logic [3:0]            waitCnt;
    logic [DEPTH_LOG2-1:0] latAddr;
    logic [7:0]            latData;
    logic                  latWrite;

    logic oneOp, inRange, validReq, badReq, badRead;
    logic accept, reqErr;

    // A request is well-formed only with exactly one op and an address inside the array.
    assign oneOp    = MemRead ^ MemWrite;
    assign inRange  = (addr >> DEPTH_LOG2) == 8'd0;
    assign validReq = oneOp && inRange;
    assign badReq   = (MemRead && MemWrite) || (oneOp && !inRange);
    assign badRead  = MemRead && !MemWrite && !inRange;
    assign fsmState = state;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = IDLE;
        stall     = 1'b0;
        accept    = 1'b0;
        reqErr    = 1'b0;
        case (state)
            IDLE: begin
                if (validReq) begin
                    nextState = BUSY;
                    stall     = 1'b1;
                    accept    = 1'b1;
                end else begin
                    nextState = IDLE;
                    reqErr    = badReq;
                end
            end
            BUSY: begin
                stall     = 1'b1;
                nextState = (waitCnt == 4'd0) ? DONE : BUSY;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt  <= 4'd0;
            rdata    <= 8'h00;
            done     <= 1'b0;
            err      <= 1'b0;
            latAddr  <= '0;
            latData  <= 8'h00;
            latWrite <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            done <= 1'b0;
            err  <= reqErr;
            if (accept) begin
                latAddr  <= addr[DEPTH_LOG2-1:0];
                latData  <= wdata;
                latWrite <= MemWrite;
                waitCnt  <= 4'(LATENCY - 1);
            end
            // The access itself happens on the last BUSY edge so its result is visible in DONE.
            if (state == BUSY) begin
                if (waitCnt == 4'd0) begin
                    if (latWrite) mem[latAddr] <= latData;
                    else          rdata <= mem[latAddr];
                    done <= 1'b1;
                end else begin
                    waitCnt <= waitCnt - 4'd1;
                end
            end
            if (state == IDLE && badRead) rdata <= 8'h00;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a cycle-indexed transaction model checks every cycle, plus
// directed scenarios with hand-computed expectations for both latencies.
module tb_data_mem_ctrl;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       memRead, memWrite;
  logic [7:0] addr, wdata, rdata;
  logic       stall, done, err;
  logic [1:0] fsmState;

  logic       l1Read, l1Write;
  logic [7:0] l1Addr, l1Wdata, l1Rdata;
  logic       l1Stall, l1Done, l1Err;
  logic [1:0] l1State;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl #(.LATENCY(LAT), .DEPTH_LOG2(6)) dut (
    .clk(clk), .reset(reset), .MemRead(memRead), .MemWrite(memWrite), .addr(addr),
    .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .err(err), .fsmState(fsmState)
  );

  data_mem_ctrl #(.LATENCY(1), .DEPTH_LOG2(6)) dutL1 (
    .clk(clk), .reset(reset), .MemRead(l1Read), .MemWrite(l1Write), .addr(l1Addr),
    .wdata(l1Wdata), .rdata(l1Rdata), .stall(l1Stall), .done(l1Done), .err(l1Err),
    .fsmState(l1State)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // scoreboard: model of the main instance, indexed by cycle number
  int         cyc = 0;
  bit         mValid = 0;
  bit         inTxn = 0;
  int         doneAt = 0;
  bit         tWrite;
  logic [5:0] tAddr;
  logic [7:0] tData;
  logic [7:0] mMem [64];
  logic [7:0] expRdata;
  bit         expDone, expErr;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin : model
    bit oneOp, okReq, nDone, nErr, expStall;
    oneOp = memRead ^ memWrite;
    okReq = oneOp && (addr < 8'd64);
    if (mValid && !reset) begin
      expStall = inTxn ? (cyc < doneAt) : okReq;
      chk("stall", 32'(stall), 32'(expStall));
      chk("done", 32'(done), 32'(expDone));
      chk("err", 32'(err), 32'(expErr));
      chk("rdata", 32'(rdata), 32'(expRdata));
      if (done && exp_q.size() > 0) chk("read_q", 32'(rdata), 32'(exp_q.pop_front()));
    end
    nDone = 0;
    nErr  = 0;
    if (reset) begin
      for (int i = 0; i < 64; i++) mMem[i] = 8'h00;
      expRdata = 8'h00;
      inTxn    = 0;
      mValid   = 1;
      exp_q.delete();
    end else if (inTxn) begin
      if (cyc == doneAt - 1) begin
        if (tWrite) mMem[tAddr] = tData;
        else begin
          expRdata = mMem[tAddr];
          exp_q.push_back(mMem[tAddr]);
        end
        nDone = 1;
      end
      if (cyc == doneAt) inTxn = 0;
    end else if (okReq) begin
      inTxn  = 1;
      doneAt = cyc + LAT + 1;
      tWrite = memWrite;
      tAddr  = addr[5:0];
      tData  = wdata;
    end else if (memRead || memWrite) begin
      nErr = 1;
      if (oneOp && memRead) expRdata = 8'h00;
    end
    expDone = nDone;
    expErr  = nErr;
    cyc++;
  end

  // driver tasks
  task automatic setIn(input bit useL1, input bit r, input bit w, input logic [7:0] a,
                       input logic [7:0] d);
    if (useL1) begin
      l1Read = r; l1Write = w; l1Addr = a; l1Wdata = d;
    end else begin
      memRead = r; memWrite = w; addr = a; wdata = d;
    end
  endtask

  // Issues one request, holding it while stall is high (addr switches to altA in BUSY),
  // and observes an 8-cycle window.
  task automatic access(input bit useL1, input bit r, input bit w, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] altA,
                        output int nStall, output int nDone, output int doneIdx,
                        output int nErr, output logic [7:0] rdDone, output logic [7:0] rdEnd);
    bit s, dn, er;
    logic [7:0] rv;
    nStall = 0; nDone = 0; doneIdx = -1; nErr = 0; rdDone = 8'hxx;
    @(posedge clk); #1;
    setIn(useL1, r, w, a, d);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s  = useL1 ? l1Stall : stall;
      dn = useL1 ? l1Done  : done;
      er = useL1 ? l1Err   : err;
      rv = useL1 ? l1Rdata : rdata;
      nStall += int'(s);
      nErr   += int'(er);
      if (dn) begin
        nDone++;
        doneIdx = i;
        rdDone  = rv;
      end
      @(posedge clk); #1;
      if (!s) setIn(useL1, 0, 0, 8'h00, 8'h00);
      else    setIn(useL1, r, w, altA, d);
    end
    rdEnd = useL1 ? l1Rdata : rdata;
  endtask

  int nS, nD, dI, nE;
  logic [7:0] rdD, rdE;

  initial begin
    reset = 1'b1;
    setIn(0, 0, 0, 8'h00, 8'h00);
    setIn(1, 0, 0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rdata", 32'(rdata), 32'h00);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_state", 32'(fsmState), 32'h0);

    // write A5 to 03 then read it back
    access(0, 0, 1, 8'h03, 8'hA5, 8'h03, nS, nD, dI, nE, rdD, rdE);
    chk("wr03_stall", 32'(nS), 32'd3);
    chk("wr03_done", 32'(nD), 32'd1);
    chk("wr03_doneat", 32'(dI), 32'd3);
    chk("wr03_rdata", 32'(rdE), 32'h00);
    access(0, 1, 0, 8'h03, 8'h00, 8'h03, nS, nD, dI, nE, rdD, rdE);
    chk("rd03_stall", 32'(nS), 32'd3);
    chk("rd03_doneat", 32'(dI), 32'd3);
    chk("rd03_data", 32'(rdD), 32'hA5);

    // out-of-range write then read
    access(0, 0, 1, 8'h40, 8'h77, 8'h40, nS, nD, dI, nE, rdD, rdE);
    chk("wr40_err", 32'(nE), 32'd1);
    chk("wr40_done", 32'(nD), 32'd0);
    chk("wr40_keep", 32'(rdE), 32'hA5);
    access(0, 1, 0, 8'h40, 8'h00, 8'h40, nS, nD, dI, nE, rdD, rdE);
    chk("rd40_err", 32'(nE), 32'd1);
    chk("rd40_stall", 32'(nS), 32'd0);
    chk("rd40_rdata", 32'(rdE), 32'h00);

    // both ops at once
    access(0, 1, 1, 8'h01, 8'h99, 8'h01, nS, nD, dI, nE, rdD, rdE);
    chk("both_err", 32'(nE), 32'd1);
    chk("both_stall", 32'(nS), 32'd0);
    chk("both_done", 32'(nD), 32'd0);
    access(0, 1, 0, 8'h01, 8'h00, 8'h01, nS, nD, dI, nE, rdD, rdE);
    chk("rd01_data", 32'(rdD), 32'h00);

    // reset in the second BUSY cycle of a write
    nD = 0;
    @(posedge clk); #1 setIn(0, 0, 1, 8'h05, 8'h3C);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); nD += int'(done);
    @(posedge clk); #1 reset = 1'b0;
    setIn(0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nD += int'(done);
      if (i == 0) chk("abort_state", 32'(fsmState), 32'h0);
    end
    chk("abort_done", 32'(nD), 32'd0);
    access(0, 1, 0, 8'h05, 8'h00, 8'h05, nS, nD, dI, nE, rdD, rdE);
    chk("rd05_data", 32'(rdD), 32'h00);

    // back-to-back reads of 00 and 3F, request held through DONE
    access(0, 0, 1, 8'h00, 8'h11, 8'h00, nS, nD, dI, nE, rdD, rdE);
    access(0, 0, 1, 8'h3F, 8'h22, 8'h3F, nS, nD, dI, nE, rdD, rdE);
    nD = 0; dI = -1; nS = 0;
    @(posedge clk); #1 setIn(0, 1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        nD++;
        dI = i;
        chk("b2b_data", 32'(rdata), (nD == 1) ? 32'h11 : 32'h22);
        if (nD == 1) addr = 8'h3F;
        else setIn(0, 0, 0, 8'h00, 8'h00);
      end
      if (i == 4) nS = int'(stall);
    end
    chk("b2b_count", 32'(nD), 32'd2);
    chk("b2b_last", 32'(dI), 32'd7);
    chk("b2b_accept", 32'(nS), 32'd1);

    // latency-1 instance: the read keeps its latched address
    access(1, 0, 1, 8'h07, 8'h5A, 8'h07, nS, nD, dI, nE, rdD, rdE);
    access(1, 1, 0, 8'h07, 8'h00, 8'h08, nS, nD, dI, nE, rdD, rdE);
    chk("l1_stall", 32'(nS), 32'd2);
    chk("l1_doneat", 32'(dI), 32'd2);
    chk("l1_data", 32'(rdD), 32'h5A);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int op;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) == 0);
      op = $urandom_range(0, 9);
      memRead  = (op >= 4 && op <= 5) || op == 8;
      memWrite = (op >= 6 && op <= 7) || op == 8;
      if ($urandom_range(0, 5) == 0) addr = 8'($urandom_range(64, 255));
      else if ($urandom_range(0, 1) == 0) addr = 8'($urandom_range(0, 15));
      else addr = 8'($urandom_range(0, 63));
      wdata = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    setIn(0, 0, 0, 8'h00, 8'h00);
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
